// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubbles and redirects for a
// 5-stage in-order core, plus saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_wb_load,
    input  logic [4:0]       ex_wb_rd,
    input  logic             ex_mispredict,
    input  logic             ex_invalid_inst,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_redirect,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, REFILL, HALT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             lu;
    logic             stall_ev, flush_ev;

    assign lu = ex_wb_load && (ex_wb_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_wb_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_wb_rd)));

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_redirect = 1'b0;
        halted      = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        if (state_q == HALT) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
            halted = 1'b1;
        end else if (mem_busy) begin
            // Freeze everything, including a pending REFILL, until memory frees up
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
            stall_ev = 1'b1;
        end else if (ex_invalid_inst) begin
            // Drain the older instructions, squash the younger ones, stop fetch
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = HALT;
        end else if (ex_mispredict) begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_ev    = 1'b1;
            state_d     = REFILL;
        end else if (state_q == REFILL) begin
            // Synchronous fetch still returns the wrong-path word this cycle
            if_id_flush = 1'b1;
            state_d     = RUN;
        end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_ev    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_ev && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, corner sequences and
// randomized traffic checked against a rule-level model.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_wb_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_wb_load = 0;
    logic       ex_mispredict = 0, ex_invalid_inst = 0, mem_busy = 0;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, pc_redirect, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic       s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic       s_if_id_flush, s_id_ex_flush, s_pc_redirect, s_halted;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_wb_load(ex_wb_load),
        .ex_wb_rd(ex_wb_rd), .ex_mispredict(ex_mispredict),
        .ex_invalid_inst(ex_invalid_inst), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pc_redirect(pc_redirect), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    // Narrow-counter copy sharing all stimulus, to exercise saturation
    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_wb_load(ex_wb_load),
        .ex_wb_rd(ex_wb_rd), .ex_mispredict(ex_mispredict),
        .ex_invalid_inst(ex_invalid_inst), .mem_busy(mem_busy),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush),
        .id_ex_flush(s_id_ex_flush), .pc_redirect(s_pc_redirect), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, ld;
        logic [4:0] rd;
        logic       mp, inv, busy;
        logic [4:0] en;     // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [1:0] fl;     // {if_id, id_ex}
        logic       redir, hlt;
        int         sc, fc; // counter values seen before this vector's edge
    } vec_t;

    vec_t vt[18];

    // model state
    bit m_halt, m_refill;
    int m_stall, m_flush;

    function automatic int sat(int v, int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input logic [4:0] en, input logic [1:0] fl, input logic rd,
                           input logic h, input int sc, input int fc);
        chk("enables", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), int'(en));
        chk("flushes", int'({if_id_flush, id_ex_flush}), int'(fl));
        chk("pc_redirect", int'(pc_redirect), int'(rd));
        chk("halted", int'(halted), int'(h));
        chk("stall_cnt", int'(stall_cnt), sat(sc, 16));
        chk("flush_cnt", int'(flush_cnt), sat(fc, 16));
        chk("stall_cnt4", int'(s_stall_cnt), sat(sc, 4));
        chk("flush_cnt4", int'(s_flush_cnt), sat(fc, 4));
        chk("enables4", int'({s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en}), int'(en));
    endtask

    task automatic set_in(input logic [4:0] rs1, rs2, input logic u1, u2, ld,
                          input logic [4:0] rd, input logic mp, inv, busy);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_wb_load = ld; ex_wb_rd = rd; ex_mispredict = mp;
        ex_invalid_inst = inv; mem_busy = busy;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called at posedge+1; pulses rst asynchronously and checks RUN decode of idle inputs
    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        chk_all(5'b11111, 2'b00, 1'b0, 1'b0, 0, 0);
        #1 rst = 1'b0;
        m_halt = 0; m_refill = 0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expected outputs and next state from the priority rules
    task automatic model_cycle();
        bit lu;
        logic [4:0] en;
        logic [1:0] fl;
        logic rd;
        lu = ex_wb_load && ex_wb_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_wb_rd) || (id_use_rs2 && id_rs2 == ex_wb_rd));
        en = 5'b11111; fl = 2'b00; rd = 1'b0;
        @(negedge clk);
        if (m_halt) en = 5'b00000;
        else if (mem_busy) en = 5'b00000;
        else if (ex_invalid_inst) begin en = 5'b01111; fl = 2'b11; end
        else if (ex_mispredict) begin fl = 2'b11; rd = 1'b1; end
        else if (m_refill) fl = 2'b10;
        else if (lu) begin en = 5'b00111; fl = 2'b01; end
        chk_all(en, fl, rd, m_halt, m_stall, m_flush);
        @(posedge clk);
        if (!m_halt) begin
            if (mem_busy) m_stall++;
            else if (ex_invalid_inst) begin m_halt = 1; m_refill = 0; end
            else if (ex_mispredict) begin m_flush++; m_refill = 1; end
            else if (m_refill) m_refill = 0;
            else if (lu) m_stall++;
        end
        #1;
    endtask

    initial begin
        //          rs1   rs2   u1 u2 ld rd    mp inv busy en        fl     rd  h  sc fc
        vt[0]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 0, 0};
        vt[1]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 5'b00111, 2'b01, 0, 0, 0, 0};
        vt[2]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 1, 0};
        vt[3]  = '{5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 1, 0};
        vt[4]  = '{5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 1, 0};
        vt[5]  = '{5'd1, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, 5'b00111, 2'b01, 0, 0, 1, 0};
        vt[6]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 5'b11111, 2'b11, 1, 0, 2, 0};
        vt[7]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 5'b11111, 2'b11, 1, 0, 2, 1};
        vt[8]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 5'b11111, 2'b10, 0, 0, 2, 2};
        vt[9]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 5'b11111, 2'b00, 0, 0, 2, 2};
        vt[10] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1, 5'b00000, 2'b00, 0, 0, 2, 2};
        vt[11] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 2'b00, 0, 0, 3, 2};
        vt[12] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 5'b11111, 2'b11, 1, 0, 4, 2};
        vt[13] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 2'b00, 0, 0, 4, 3};
        vt[14] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 5'b11111, 2'b10, 0, 0, 5, 3};
        vt[15] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 5'b01111, 2'b11, 0, 0, 5, 3};
        vt[16] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 5'b00000, 2'b00, 0, 1, 5, 3};
        vt[17] = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 5'b00000, 2'b00, 0, 1, 5, 3};

        @(posedge clk); #1;
        do_reset();

        foreach (vt[i]) begin
            set_in(vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].ld, vt[i].rd,
                   vt[i].mp, vt[i].inv, vt[i].busy);
            @(negedge clk);
            chk_all(vt[i].en, vt[i].fl, vt[i].redir, vt[i].hlt, vt[i].sc, vt[i].fc);
            tick();
        end

        // Reset out of HALT
        do_reset();

        // Reset in the middle of REFILL must not leave the fetch flush pending
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0);
        tick();
        idle();
        #1 chk("refill_flush_before_rst", int'(if_id_flush), 1);
        do_reset();

        // mem_busy holds off a pending mispredict for three cycles
        set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("busy_enables", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 0);
            chk("busy_redirect", int'(pc_redirect), 0);
            tick();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        chk("busy_stall_cnt", int'(stall_cnt), 3);
        chk("busy_flush_cnt_before", int'(flush_cnt), 0);
        chk("busy_then_redirect", int'(pc_redirect), 1);
        tick();
        idle();
        @(negedge clk);
        chk("busy_flush_cnt_after", int'(flush_cnt), 1);
        tick();

        // 20 consecutive load-use cycles saturate the narrow counter
        do_reset();
        set_in(5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0, 0);
        repeat (20) tick();
        idle();
        @(negedge clk);
        chk("sat_stall_cnt4", int'(s_stall_cnt), 15);
        chk("sat_stall_cnt16", int'(stall_cnt), 20);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (m_halt && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                       5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 40) == 0),
                       1'($urandom_range(0, 5) == 0));
                model_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of each saturating performance counter.
REQ-002 clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-006 ex_wb_load  input  1  instruction in EX is a load.
REQ-007 ex_wb_rd  input  5  destination register of the instruction in EX.
REQ-008 ex_mispredict  input  1  EX branch/jump resolved against the prediction; redirect required.
REQ-009 ex_invalid_inst  input  1  instruction in EX is illegal.
REQ-010 mem_busy  input  1  data memory cannot accept or complete its access this cycle.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  stage-register enables.
REQ-012 if_id_flush, id_ex_flush  output  1 each  bubble insertion into IF/ID and ID/EX.
REQ-013 pc_redirect  output  1  PC mux selects the EX-computed target.
REQ-014 halted  output  1  core is stopped on an illegal instruction.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-016 The FSM SHALL have three states: RUN, REFILL, HALT. All enable/flush/redirect outputs are combinational from state and inputs.
REQ-017 Load-use hazard (lu) SHALL be: ex_wb_load & ex_wb_rd!=0 & ((id_use_rs1 & id_rs1==ex_wb_rd) | (id_use_rs2 & id_rs2==ex_wb_rd)).
REQ-018 Priority, highest first: HALT state, mem_busy, ex_invalid_inst, ex_mispredict, REFILL state, lu, normal.
REQ-019 HALT: all five enables 0, both flushes 0, pc_redirect 0, halted 1; HALT is sticky until rst.
REQ-020 mem_busy=1 (not HALT): all enables 0, flushes 0, pc_redirect 0; state unchanged; no ex_invalid_inst, ex_mispredict or lu action taken that cycle.
REQ-021 ex_invalid_inst=1 (RUN or REFILL, mem_busy=0): pc_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1, if_id_en=1, id_ex_en=1; next state HALT.
REQ-022 ex_mispredict=1 (RUN or REFILL, mem_busy=0, no invalid): pc_redirect=1, all enables 1, if_id_flush=1, id_ex_flush=1; next state REFILL.
REQ-023 REFILL (no higher-priority event): all enables 1, if_id_flush=1 (discards the stale synchronous-fetch word), id_ex_flush=0, pc_redirect=0; next state RUN; lu ignored.
REQ-024 lu in RUN (no higher-priority event): pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; exactly one bubble; state stays RUN.
REQ-025 Normal RUN: all enables 1, flushes 0, pc_redirect 0.
REQ-026 Whenever a flush output is 1 the corresponding stage enable SHALL also be 1.
REQ-027 stall_cnt SHALL increment by 1 on each edge where lu bubble (REQ-024) or mem_busy stall (REQ-020) is applied; flush_cnt on each edge where ex_mispredict is acted on (REQ-022).
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 Back-to-back ex_mispredict in REFILL SHALL be acted on again (re-enter REFILL) and counted.

Reset
REQ-030 On rst: state RUN, stall_cnt=0, flush_cnt=0, halted=0; outputs then follow RUN decode of current inputs.
REQ-031 rst asserted mid-REFILL or in HALT SHALL return to RUN on the same asynchronous event, with no residual flush.

Verification
REQ-032 ex_wb_load=1, ex_wb_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0->1; next cycle all enables 1.
REQ-033 Same as REQ-032 but ex_wb_rd=0, or id_use_rs1=0 -> no stall, all enables 1, stall_cnt unchanged.
REQ-034 ex_mispredict pulse -> cycle 0: pc_redirect=1, both flushes 1; cycle 1 (REFILL): if_id_flush=1, id_ex_flush=0; cycle 2: RUN; flush_cnt=1.
REQ-035 mem_busy=1 for 3 cycles with ex_mispredict=1 held -> all enables 0 for 3 cycles, flush_cnt=0, stall_cnt=3; on 4th cycle redirect taken, flush_cnt=1.
REQ-036 ex_invalid_inst=1 together with ex_mispredict=1 -> invalid wins: pc_en=0, both flushes 1, pc_redirect=0; next cycle halted=1, all enables 0; persists until rst.
REQ-037 CNT_W=4, 20 consecutive lu cycles -> stall_cnt reaches 15 and holds at 15.
